wb_regfile: RTL and testbench

- Writeback stage and architectural register file of the toy RISC pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the writeback value.
- Commits that value into a 32x32 register file and serves the two decode-stage read ports.
- Also exports the writeback value and a retired-write counter for forwarding and debug.

---
 rtl/wb_regfile_pkg.sv | 19 +
 rtl/wb_mux.sv | 25 ++
 rtl/wb_regfile.sv | 73 +++++++
 tb/tb_wb_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and architectural register file.
// Consumed by wb_mux and wb_regfile (optional bypass macro: REGFILE_BYPASS_EN).
package wb_regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    // Register write enable is active-low throughout the pipeline.
    localparam logic WEN_ACTIVE = 1'b0;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_RS   = 2'd3;

endpackage

// File: rtl/wb_mux.sv
// Writeback source select: picks the value committed to the register file.
// Purely combinational; the select encoding comes from wb_regfile_pkg.
module wb_mux
    import wb_regfile_pkg::*;
(
    input  logic [1:0]      sel_wb,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] pc_add4,
    input  logic [XLEN-1:0] dout0,
    output logic [XLEN-1:0] wb_data
);

    always_comb begin
        wb_data = alu_out;
        case (sel_wb)
            SEL_ALU:  wb_data = alu_out;
            SEL_LOAD: wb_data = load_data;
            SEL_PC4:  wb_data = pc_add4;
            SEL_RS:   wb_data = dout0;
            default:  wb_data = alu_out;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 32x32 architectural register file with two async read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [1:0]      SelWB_W,
    input  logic            WEN_W,
    input  logic [31:0]     ALUOUT_W,
    input  logic [31:0]     LoadData_W,
    input  logic [31:0]     PCADD4_W,
    input  logic [31:0]     DOUT0_W,
    input  logic [4:0]      WA_W,
    input  logic [4:0]      RA0,
    input  logic [4:0]      RA1,
    output logic [31:0]     RD0,
    output logic [31:0]     RD1,
    output logic [31:0]     WB_DATA,
    output logic            WB_VALID,
    output logic [31:0]     WB_CNT
);

    logic [XLEN-1:0] wb_data;
    logic            wb_valid;
    logic [XLEN-1:0] regs [NREG];
    logic [31:0]     wb_cnt_q;

    wb_mux u_wb_mux (
        .sel_wb    (SelWB_W),
        .alu_out   (ALUOUT_W),
        .load_data (LoadData_W),
        .pc_add4   (PCADD4_W),
        .dout0     (DOUT0_W),
        .wb_data   (wb_data)
    );

    // Gated by RSTN so no write is reported while the block is held in reset.
    assign wb_valid = RSTN && (WEN_W == WEN_ACTIVE) && (WA_W != ZERO_REG);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[WA_W] <= wb_data;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wb_cnt_q <= '0;
        end else if (wb_valid) begin
            wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    always_comb begin
        RD0 = (RA0 == ZERO_REG) ? '0 : regs[RA0];
        RD1 = (RA1 == ZERO_REG) ? '0 : regs[RA1];
`ifdef REGFILE_BYPASS_EN
        // wb_valid already excludes register zero, so a match implies a nonzero address.
        if (wb_valid && (RA0 == WA_W)) RD0 = wb_data;
        if (wb_valid && (RA1 == WA_W)) RD1 = wb_data;
`endif
    end

    assign WB_DATA  = wb_data;
    assign WB_VALID = wb_valid;
    assign WB_CNT   = wb_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference model feeds a scoreboard queue
// at drive time; DUT outputs are popped and compared mid-low-phase.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [1:0]  SelWB_W;
    logic        WEN_W;
    logic [31:0] ALUOUT_W, LoadData_W, PCADD4_W, DOUT0_W;
    logic [4:0]  WA_W, RA0, RA1;
    logic [31:0] RD0, RD1, WB_DATA, WB_CNT;
    logic        WB_VALID;

    always #5 CLK = ~CLK;

    wb_regfile dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .SelWB_W    (SelWB_W),
        .WEN_W      (WEN_W),
        .ALUOUT_W   (ALUOUT_W),
        .LoadData_W (LoadData_W),
        .PCADD4_W   (PCADD4_W),
        .DOUT0_W    (DOUT0_W),
        .WA_W       (WA_W),
        .RA0        (RA0),
        .RA1        (RA1),
        .RD0        (RD0),
        .RD1        (RD1),
        .WB_DATA    (WB_DATA),
        .WB_VALID   (WB_VALID),
        .WB_CNT     (WB_CNT)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [32];
    logic [31:0] cnt_m;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", exp_q.size(), 32'd1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, obs, e);
        end
    endtask

    function automatic logic [31:0] m_wb();
        case (SelWB_W)
            2'd0:    return ALUOUT_W;
            2'd1:    return LoadData_W;
            2'd2:    return PCADD4_W;
            default: return DOUT0_W;
        endcase
    endfunction

    function automatic logic m_valid();
        return (RSTN === 1'b1) && (WEN_W === 1'b0) && (WA_W != 5'd0);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (m_valid() && ra == WA_W) return m_wb();
`endif
        return mem_m[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        cnt_m = 32'd0;
    endtask

    task automatic sample_all(input string tag);
        sb_push({tag, ".rd0"},      m_rd(RA0));
        sb_push({tag, ".rd1"},      m_rd(RA1));
        sb_push({tag, ".wb_data"},  m_wb());
        sb_push({tag, ".wb_valid"}, {31'd0, m_valid()});
        sb_push({tag, ".wb_cnt"},   cnt_m);
        #1;
        sb_pop(RD0);
        sb_pop(RD1);
        sb_pop(WB_DATA);
        sb_pop({31'd0, WB_VALID});
        sb_pop(WB_CNT);
    endtask

    task automatic step();
        @(posedge CLK);
        if (m_valid()) begin
            mem_m[WA_W] = m_wb();
            cnt_m++;
        end
        @(negedge CLK);
    endtask

    task automatic drive(input logic [1:0] sel, input logic wen, input logic [4:0] wa,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4, input logic [31:0] d0);
        SelWB_W = sel; WEN_W = wen; WA_W = wa;
        ALUOUT_W = alu; LoadData_W = ld; PCADD4_W = pc4; DOUT0_W = d0;
    endtask

    logic [31:0] src [4];

    initial begin
        src[0] = 32'h1111_1111; src[1] = 32'h2222_2222;
        src[2] = 32'h3333_3333; src[3] = 32'h4444_4444;

        // Reset then idle
        RSTN = 1'b1;
        drive(2'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        RA0 = 5'd0; RA1 = 5'd0;
        model_reset();
        #1 RSTN = 1'b0;
        sample_all("in_reset");
        step();
        step();
        RSTN = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RA0 = i[4:0];
            RA1 = 5'(31 - i);
            sample_all("idle");
        end

        // Mux select and write to r5..r8
        for (int k = 0; k < 4; k++) begin
            drive(k[1:0], 1'b0, 5'(5 + k), src[0], src[1], src[2], src[3]);
            RA0 = 5'd1; RA1 = 5'd2;
            sample_all("mux");
            step();
        end
        drive(2'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            RA0 = 5'(5 + k); RA1 = 5'(8 - k);
            sample_all("readback");
        end
        check_val("cnt_after_4", WB_CNT, 32'd4);

        // Register zero write discarded
        drive(2'd0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
        RA0 = 5'd0; RA1 = 5'd5;
        sample_all("r0_write");
        step();
        sample_all("r0_after");

        // Disabled write
        drive(2'd0, 1'b1, 5'd3, 32'hCAFE_F00D, 32'd0, 32'd0, 32'd0);
        RA0 = 5'd3; RA1 = 5'd3;
        sample_all("wen_hi");
        step();
        sample_all("wen_hi_after");

        // Same-cycle read-after-write on r9
        drive(2'd1, 1'b0, 5'd9, 32'd0, 32'h0000_0001, 32'd0, 32'd0);
        RA0 = 5'd4; RA1 = 5'd4;
        step();
        drive(2'd2, 1'b0, 5'd9, 32'd0, 32'd0, 32'h0000_ABCD, 32'd0);
        RA0 = 5'd9; RA1 = 5'd9;
        sample_all("raw_same");
        step();
        drive(2'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        sample_all("raw_next");

        // Counter wrap
        force dut.wb_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_cnt_q;
        cnt_m = 32'hFFFF_FFFF;
        drive(2'd3, 1'b0, 5'd10, 32'd0, 32'd0, 32'd0, 32'h0000_0055);
        RA0 = 5'd10; RA1 = 5'd9;
        sample_all("wrap_pre");
        step();
        drive(2'd0, 1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        sample_all("wrap_post");
        check_val("wrap_zero", WB_CNT, 32'd0);

        // Async reset between edges during a pending write
        drive(2'd0, 1'b0, 5'd11, 32'h0000_0077, 32'd0, 32'd0, 32'd0);
        RA0 = 5'd5; RA1 = 5'd10;
        sample_all("pre_rst");
        #1;
        RSTN = 1'b0;
        model_reset();
        sample_all("mid_rst");
        WEN_W = 1'b1;
        step();
        RSTN = 1'b1;
        for (int i = 0; i < 32; i += 2) begin
            RA0 = i[4:0];
            RA1 = 5'(i + 1);
            sample_all("post_rst");
        end

        if (exp_q.size() != 0) check_val("sb_leftover", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
